// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch/decode types, opcodes and the bubble instruction
package riscv_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} fetch_state_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ifid_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a fetch that returned while decode was stalled
module fetch_skid (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  output logic        empty,
  output logic [31:0] q_pc,
  output logic [31:0] q_instr
);
  logic full;
  always_ff @(posedge clk) begin
    full <= (reset || clear) ? 1'b0 : load ? 1'b1 : unload ? 1'b0 : full;
    if (load) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
    end
  end
  assign empty = !full;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, req/ack instruction fetch and IF/ID register with stall and redirect flush
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
);
  import riscv_pkg::*;
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, tgt, tgt_n, target, skid_pc, skid_instr;
  ifid_t ifid, ifid_n;
  logic skid_load, skid_unload, skid_clear, skid_empty;
  assign target = redirect_pc_i & ~32'd3;
  fetch_skid u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .unload(skid_unload), .clear(skid_clear),
    .d_pc(pc), .d_instr(imem_rdata_i), .empty(skid_empty), .q_pc(skid_pc), .q_instr(skid_instr)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    tgt_n = tgt;
    ifid_n = ifid;
    skid_load = 1'b0;
    skid_unload = 1'b0;
    skid_clear = 1'b0;
    if (redirect_i) begin
      ifid_n.valid = 1'b0;
      ifid_n.instr = NOP_INSTR;
      skid_clear = 1'b1;
      // an unanswered request must complete at its old address before the target is fetched
      if ((state == S_FETCH || state == S_DROP) && !imem_ack_i) begin
        tgt_n = target;
        state_n = S_DROP;
      end else begin
        pc_n = target;
        state_n = S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: state_n = S_FETCH;
        S_FETCH: if (imem_ack_i) begin
          pc_n = pc + 32'd4;
          if (stall_i) begin
            skid_load = 1'b1;
            state_n = S_HOLD;
          end else ifid_n = '{valid: 1'b1, pc: pc, pc4: pc + 32'd4, instr: imem_rdata_i};
        end
        S_HOLD: if (!stall_i) begin
          ifid_n = '{valid: !skid_empty, pc: skid_pc, pc4: skid_pc + 32'd4, instr: skid_instr};
          skid_unload = 1'b1;
          state_n = S_FETCH;
        end
        S_DROP: if (imem_ack_i) begin
          pc_n = tgt;
          state_n = S_FETCH;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      tgt <= RESET_PC;
      ifid <= '{valid: 1'b0, pc: 32'd0, pc4: 32'd4, instr: NOP_INSTR};
    end else begin
      state <= state_n;
      pc <= pc_n;
      tgt <= tgt_n;
      ifid <= ifid_n;
    end
  end
  assign imem_req_o = (state == S_FETCH) || (state == S_DROP);
  assign imem_addr_o = pc;
  assign ifid_valid_o = ifid.valid;
  assign ifid_pc_o = ifid.pc;
  assign ifid_pc4_o = ifid.pc4;
  assign ifid_instr_o = ifid.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed steps with a scoreboard of expected IF/ID entries
module tb_fetch_stage;
  import riscv_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, stall_i, redirect_i, imem_ack_i, imem_req_o, ifid_valid_o;
  logic [31:0] redirect_pc_i, imem_rdata_i, imem_addr_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o;
  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .ifid_valid_o(ifid_valid_o),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o)
  );
  ifid_t sb[$];
  int errors = 0, checks = 0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] rp,
                      input logic ak, input logic [31:0] rdat);
    logic pre_req;
    logic [31:0] pre_addr;
    ifid_t e;
    reset = rst; stall_i = st; redirect_i = rd; redirect_pc_i = rp; imem_ack_i = ak; imem_rdata_i = rdat;
    #1;
    pre_req = imem_req_o;
    pre_addr = imem_addr_o;
    @(posedge clk);
    #1;
    if (pre_req === 1'b1 && !ak && !rst) begin
      chk("req_held", {31'd0, imem_req_o}, 32'd1);
      chk("addr_stable", imem_addr_o, pre_addr);
    end
    if (ifid_valid_o === 1'b1 && (!prev_valid || ifid_pc_o !== prev_pc)) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_ifid: observed pc %h expected no update", ifid_pc_o);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ifid_pc", ifid_pc_o, e.pc);
        chk("ifid_pc4", ifid_pc4_o, e.pc4);
        chk("ifid_instr", ifid_instr_o, e.instr);
      end
    end
    prev_valid = ifid_valid_o;
    prev_pc = ifid_pc_o;
  endtask
  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    chk("fetch_req", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_addr", imem_addr_o, addr);
    sb.push_back('{valid: 1'b1, pc: addr, pc4: addr + 32'd4, instr: data});
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, data);
  endtask
  task automatic chk_reset_state();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rst_instr", ifid_instr_o, NOP_INSTR);
    chk("rst_pc", ifid_pc_o, 32'd0);
    chk("rst_pc4", ifid_pc4_o, 32'd4);
  endtask
  initial begin
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk_reset_state();
    idle();
    fetch(32'h0, 32'h0050_0093);
    fetch(32'h4, 32'h00A0_0113);
    fetch(32'h8, 32'h0000_0033);
    fetch(32'hC, 32'h0020_8193);
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", imem_addr_o, 32'h10);
      idle();
    end
    chk("wait_ifid_pc", ifid_pc_o, 32'hC);
    fetch(32'h10, 32'h0041_2203);
    chk("stall_addr", imem_addr_o, 32'h14);
    sb.push_back('{valid: 1'b1, pc: 32'h14, pc4: 32'h18, instr: 32'h0031_2423});
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0031_2423);
    for (int i = 0; i < 2; i++) begin
      chk("stall_req", {31'd0, imem_req_o}, 32'd0);
      chk("stall_ifid_pc", ifid_pc_o, 32'h10);
      step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    end
    chk("hold_req", {31'd0, imem_req_o}, 32'd0);
    idle();
    chk("release_addr", imem_addr_o, 32'h18);
    step(1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'd0);
    chk("redir_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("redir_instr", ifid_instr_o, NOP_INSTR);
    chk("redir_pc_hold", ifid_pc_o, 32'h14);
    chk("drop_addr", imem_addr_o, 32'h18);
    idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    chk("drop_valid", {31'd0, ifid_valid_o}, 32'd0);
    fetch(32'h100, 32'h0000_0013);
    step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 32'hBAD0_0000);
    chk("stall_redir_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("stall_redir_req", {31'd0, imem_req_o}, 32'd1);
    fetch(32'h200, 32'h0010_0073);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0);
    chk("drop2_addr", imem_addr_o, 32'h204);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBAD1_1111);
    chk_reset_state();
    idle();
    fetch(32'h0, 32'h0050_0093);
    step(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
    chk("drop3_addr", imem_addr_o, 32'h4);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBAD2_2222);
    fetch(32'hFFFF_FFFC, 32'h0000_006F);
    chk("wrap_pc4", ifid_pc4_o, 32'd0);
    fetch(32'h0, 32'h00A0_0113);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
